// File: rtl/pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_gen_pkg
// Description : Shared state encoding and sizing helpers for the pulse train
//               generator and its phase timer.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_gen_pkg;

    // Controller states; encoding is fixed so it can be probed from outside.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Ceiling log2, never less than 1 so a timer always has at least one bit.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Larger of two integers, used to size the shared phase timer.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : pulse_phase_timer
// Description : Loadable down-counter with a zero flag. It parks at zero and
//               is reloaded by the controller at the start of every phase.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_phase_timer #(
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    output logic          o_zero
);

    logic [TW-1:0] r_count;

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - TW'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_gen
// Description : Emits a burst of count_in pulses, each HIGH_CYCLES high and
//               LOW_CYCLES low, then strobes done for one cycle.
//               Optional macro PULSE_TRAIN_GEN_ABORT_EN adds an abort input
//               that ends a running burst early.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] count_in,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remaining
);

    localparam int TW = clog2_min1(max2(HIGH_CYCLES, LOW_CYCLES));
    localparam logic [TW-1:0] c_HIGH_RELOAD = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0] c_LOW_RELOAD  = TW'(LOW_CYCLES - 1);

    state_t           r_state;
    logic             r_pulse;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_remaining;

    logic             w_abort;
    logic             w_load;
    logic [TW-1:0]    w_load_val;
    logic             w_zero;

`ifdef PULSE_TRAIN_GEN_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Reload the phase timer on every transition into HIGH or LOW.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = c_HIGH_RELOAD;
        case (r_state)
            ST_IDLE: begin
                if (start && (count_in != '0)) begin
                    w_load = 1'b1;
                end
            end
            ST_HIGH: begin
                if (!w_abort && w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = c_LOW_RELOAD;
                end
            end
            ST_LOW: begin
                if (!w_abort && w_zero && (r_remaining != '0)) begin
                    w_load = 1'b1;
                end
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    pulse_phase_timer #(
        .TW (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // Burst controller; every output is a register so pulse cannot glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pulse     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (count_in != '0) begin
                            r_state     <= ST_HIGH;
                            r_remaining <= count_in;
                            r_pulse     <= 1'b1;
                            r_busy      <= 1'b1;
                        end else begin
                            r_state     <= ST_DONE;
                            r_remaining <= '0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (w_abort) begin
                        // A truncated high phase is not counted.
                        r_state <= ST_DONE;
                        r_pulse <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_zero) begin
                        r_state     <= ST_LOW;
                        r_pulse     <= 1'b0;
                        r_remaining <= r_remaining - WIDTH'(1);
                    end
                end
                ST_LOW: begin
                    if (w_abort) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_zero) begin
                        if (r_remaining == '0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_HIGH;
                            r_pulse <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pulse     = r_pulse;
    assign busy      = r_busy;
    assign done      = r_done;
    assign remaining = r_remaining;

endmodule
`default_nettype wire
